// File: rtl/cordic_pkg.sv
// Shared fixed-point constants for the CORDIC datapath.
// Samples are S1.12 and the gain coefficient is unsigned U1.12.
package cordic_pkg;

    // Q-format of samples and coefficient
    localparam int unsigned FRAC_BITS      = 12;
    localparam int unsigned ROUND_HALF     = 2048;   // 0.5 LSB after the shift
    localparam int unsigned K_WIDTH        = 13;     // unsigned U1.12 coefficient

    // CORDIC gain constants in U1.12
    localparam int unsigned K_COEF_DEFAULT = 2487;   // K    ~ 0.6073
    localparam int unsigned K_INV_GAIN     = 6745;   // 1/K  ~ 1.6468

    typedef logic [K_WIDTH-1:0] kcoef_t;

    // Product width: 2W, but never narrower than a signed W x unsigned
    // K_WIDTH product needs (W + K_WIDTH + 1 bits).
    function automatic int unsigned prod_width(input int unsigned w);
        int unsigned need;
        need = w + K_WIDTH + 1;
        return ((2 * w) > need) ? (2 * w) : need;
    endfunction

endpackage

// File: rtl/cordic_mul_rnd_sat.sv
// Combinational multiply / round-half-up / saturate for one S1.12 lane.
// q_o = sat( (d_i * K_COEF + 0.5 LSB) >>> FRAC_BITS ), sat_o flags clipping.
module cordic_mul_rnd_sat
    import cordic_pkg::*;
#(
    parameter int unsigned K_COEF = K_COEF_DEFAULT,
    parameter int unsigned W      = 14
) (
    input  logic signed [W-1:0] d_i,
    output logic signed [W-1:0] q_o,
    output logic                sat_o
);

    localparam int unsigned PW = prod_width(W);

    localparam kcoef_t                K_VAL   = kcoef_t'(K_COEF);
    localparam logic signed [PW-1:0] RND_C   = PW'(ROUND_HALF);
    // Largest / smallest value representable in W signed bits, at PW width
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] k_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] shf;

    // Signed sample times zero-extended (unsigned) coefficient, then round and shift
    always_comb begin
        d_ext = {{(PW-W){d_i[W-1]}}, d_i};
        k_ext = {{(PW-K_WIDTH){1'b0}}, K_VAL};
        prod  = d_ext * k_ext;
        rnd   = prod + RND_C;
        shf   = rnd >>> FRAC_BITS;
    end

    // Clip the shifted result into the W-bit signed range
    always_comb begin
        sat_o = 1'b0;
        q_o   = shf[W-1:0];
        if (shf > SAT_MAX) begin
            q_o   = SAT_MAX[W-1:0];
            sat_o = 1'b1;
        end else if (shf < SAT_MIN) begin
            q_o   = SAT_MIN[W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales the final X/Y micro-rotation outputs by
// K_COEF through a 2-stage valid/ready pipeline (S1 = input register,
// S2 = rounded/saturated product register) with a sticky saturation flag.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int unsigned K_COEF = K_COEF_DEFAULT,
    parameter int unsigned W      = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X_in,
    input  logic signed [W-1:0] Y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] X_out,
    output logic signed [W-1:0] Y_out,
    output logic                sat_sticky,
    input  logic                sat_clr
);

    // Stage 1: raw samples
    logic                s1_valid_q, s1_valid_d;
    logic signed [W-1:0] s1_x_q, s1_x_d;
    logic signed [W-1:0] s1_y_q, s1_y_d;

    // Stage 2: compensated samples
    logic                s2_valid_q, s2_valid_d;
    logic signed [W-1:0] s2_x_q, s2_x_d;
    logic signed [W-1:0] s2_y_q, s2_y_d;

    logic                sticky_q, sticky_d;

    // Handshake controls
    logic                s2_adv;   // S2 may load this cycle
    logic                s1_move;  // S1 content moves into S2 this cycle
    logic                s1_adv;   // S1 may load this cycle

    // Lane results from the multipliers
    logic signed [W-1:0] mul_x, mul_y;
    logic                sat_x, sat_y;

    cordic_mul_rnd_sat #(
        .K_COEF (K_COEF),
        .W      (W)
    ) u_mul_x (
        .d_i   (s1_x_q),
        .q_o   (mul_x),
        .sat_o (sat_x)
    );

    cordic_mul_rnd_sat #(
        .K_COEF (K_COEF),
        .W      (W)
    ) u_mul_y (
        .d_i   (s1_y_q),
        .q_o   (mul_y),
        .sat_o (sat_y)
    );

    // A stage advances when it is empty or its successor takes its content.
    // in_ready depends only on stage state and out_ready, never on in_valid.
    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_move = s1_valid_q && s2_adv;
        s1_adv  = !s1_valid_q || s1_move;
    end

    // Next-state for both stages; data holds whenever its stage does not advance
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d = X_in;
                s1_y_d = Y_in;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_x_d = mul_x;
                s2_y_d = mul_y;
            end
        end
    end

    // Sticky flag: a saturating load into S2 wins over a simultaneous clear
    always_comb begin
        sticky_d = sticky_q;
        if (sat_clr) begin
            sticky_d = 1'b0;
        end
        if (s1_move && (sat_x || sat_y)) begin
            sticky_d = 1'b1;
        end
    end

    // State registers; reset empties both stages and drops in-flight samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            sticky_q   <= sticky_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign X_out      = s2_x_q;
    assign Y_out      = s2_y_q;
    assign sat_sticky = sticky_q;

endmodule
